// File: rtl/packet_serial_tx.sv
// packet_serial_tx: sending end of the SOS/EOS bit-serial link.
// Reads a run of consecutive source-memory lines and shifts each word out
// MSB-first on data_out. A one-cycle sos pulse precedes the first bit, and
// eos marks the last bit. The next word is prefetched into a holding buffer
// so that words go out back-to-back with no gap bits.
module packet_serial_tx #(
    parameter int BW_MEM    = 16,
    parameter int MAX_LINES = 256,
    parameter int ADDR_W    = $clog2(MAX_LINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [BW_MEM-1:0] rd_data,
    output logic              data_out,
    output logic              sos,
    output logic              eos,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(BW_MEM);
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(BW_MEM - 1);
    localparam logic [BIT_W-1:0] PRE_LAST_BIT = BIT_W'(BW_MEM - 2);
    localparam logic [BIT_W-1:0] CAPTURE_BIT  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE      = BIT_W'(1);
    localparam logic [CNT_W-1:0] MAX_CNT      = CNT_W'(MAX_LINES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO      = CNT_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SOS,
        S_SHIFT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BW_MEM-1:0] shift_reg;
    logic [BW_MEM-1:0] shift_nxt;
    logic [BW_MEM-1:0] next_buf;
    logic [BW_MEM-1:0] buf_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_nxt;
    logic [CNT_W-1:0]  words_rem;
    logic [CNT_W-1:0]  words_nxt;
    logic [CNT_W-1:0]  num_sat;

    logic              rd_en_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              data_out_nxt;
    logic              sos_nxt;
    logic              eos_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    logic              abort_hit;
    logic              last_word;
    logic              word_end;

    // words_rem counts the word being shifted plus those still to come
    assign num_sat   = (num_words > MAX_CNT) ? MAX_CNT : num_words;
    assign abort_hit = abort && (state != S_IDLE);
    assign last_word = (words_rem == CNT_ONE);
    assign word_end  = (bit_cnt == LAST_BIT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an abort while active always returns to idle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && (num_words != '0)) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SOS;
            S_SOS:   state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (word_end && last_word) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = S_IDLE;
        end
    end

    // Next values of the registered outputs and the shift/prefetch datapath
    always_comb begin
        rd_en_nxt    = 1'b0;
        rd_addr_nxt  = rd_addr;
        data_out_nxt = 1'b0;
        sos_nxt      = 1'b0;
        eos_nxt      = 1'b0;
        done_nxt     = 1'b0;
        shift_nxt    = shift_reg;
        buf_nxt      = next_buf;
        bit_nxt      = bit_cnt;
        words_nxt    = words_rem;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = base_addr;
                        words_nxt   = num_sat;
                        bit_nxt     = '0;
                    end
                end
            end
            S_FETCH: begin
            end
            S_LOAD: begin
                shift_nxt = rd_data;
                sos_nxt   = 1'b1;
            end
            S_SOS: begin
                data_out_nxt = shift_reg[BW_MEM-1];
                shift_nxt    = {shift_reg[BW_MEM-2:0], 1'b0};
                bit_nxt      = '0;
                if (words_rem > CNT_ONE) begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = rd_addr + ADDR_ONE;
                end
            end
            S_SHIFT: begin
                if ((bit_cnt == CAPTURE_BIT) && !last_word) begin
                    buf_nxt = rd_data;
                end
                if (!word_end) begin
                    data_out_nxt = shift_reg[BW_MEM-1];
                    shift_nxt    = {shift_reg[BW_MEM-2:0], 1'b0};
                    bit_nxt      = bit_cnt + BIT_ONE;
                    eos_nxt      = last_word && (bit_cnt == PRE_LAST_BIT);
                end else if (last_word) begin
                    done_nxt  = 1'b1;
                    words_nxt = '0;
                end else begin
                    data_out_nxt = next_buf[BW_MEM-1];
                    shift_nxt    = {next_buf[BW_MEM-2:0], 1'b0};
                    bit_nxt      = '0;
                    words_nxt    = words_rem - CNT_ONE;
                    if (words_rem > CNT_TWO) begin
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = rd_addr + ADDR_ONE;
                    end
                end
            end
            default: begin
            end
        endcase

        if (abort_hit) begin
            rd_en_nxt    = 1'b0;
            data_out_nxt = 1'b0;
            sos_nxt      = 1'b0;
            eos_nxt      = 1'b0;
            done_nxt     = 1'b0;
            words_nxt    = '0;
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

    // Output and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            data_out  <= 1'b0;
            sos       <= 1'b0;
            eos       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shift_reg <= '0;
            next_buf  <= '0;
            bit_cnt   <= '0;
            words_rem <= '0;
        end else begin
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            data_out  <= data_out_nxt;
            sos       <= sos_nxt;
            eos       <= eos_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            shift_reg <= shift_nxt;
            next_buf  <= buf_nxt;
            bit_cnt   <= bit_nxt;
            words_rem <= words_nxt;
        end
    end

endmodule
